// File: rtl/mem_block_reader_if.sv
// Handshake and RAM-port bundle between the block reader, the product RAM and the word consumer.
// The slave modport is the reader's view; the master modport is the surrounding system's view.
interface mem_block_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              EN_blockRead;
    logic [ADDR_W:0]   fill_count;
    logic              RDY_blockRead;
    logic              EN_readMem;
    logic [ADDR_W-1:0] readMem_addr;
    logic [DATA_W-1:0] readMem_val;
    logic              VALID_memVal;
    logic [DATA_W-1:0] memVal_data;
    logic              memVal_ready;
    logic              rd_busy;
    logic              burst_done;

    modport slave (
        input  EN_blockRead, fill_count, readMem_val, memVal_ready,
        output RDY_blockRead, EN_readMem, readMem_addr, VALID_memVal, memVal_data,
               rd_busy, burst_done
    );

    modport master (
        output EN_blockRead, fill_count, readMem_val, memVal_ready,
        input  RDY_blockRead, EN_readMem, readMem_addr, VALID_memVal, memVal_data,
               rd_busy, burst_done
    );
endinterface

// File: rtl/mem_block_reader.sv
// Drains the product RAM as a burst: credit-limited synchronous reads feed a small
// output FIFO that streams words to the consumer under backpressure.
module mem_block_reader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 6,
    parameter int DEPTH      = 64,
    parameter int OBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_block_reader_if.slave bus
);
    localparam int PTR_W = $clog2(OBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]  OBUF_LIMIT = (CNT_W+1)'(OBUF_DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t r_state, w_state_next;

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_last_addr;
    logic [ADDR_W:0]   r_len;
    logic              r_inflight;
    logic [DATA_W-1:0] r_buf [OBUF_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_accept;
    logic              w_credit;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_drained;
    logic [ADDR_W:0]   w_fill_clamped;

    assign w_accept       = (r_state == S_IDLE) && bus.EN_blockRead;
    assign w_fill_clamped = (bus.fill_count > DEPTH_L) ? DEPTH_L : bus.fill_count;
    // Credit counts words already buffered plus the one possibly still in the RAM pipe.
    assign w_credit       = ({1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight}) < OBUF_LIMIT;
    assign w_issue        = (r_state == S_READ) && w_credit;
    assign w_last_issue   = ({1'b0, r_ptr} == (r_len - (ADDR_W+1)'(1)));
    assign w_valid        = (r_count != '0);
    assign w_push         = r_inflight;
    assign w_pop          = w_valid && bus.memVal_ready;
    // Finish in the same cycle the final word leaves, so burst_done follows the last pop directly.
    assign w_drained      = !r_inflight && (r_count == {{(CNT_W-1){1'b0}}, w_pop});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (bus.fill_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (w_issue && w_last_issue) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_last_addr <= '0;
            r_len       <= '0;
            r_inflight  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= '0;
                r_len <= w_fill_clamped;
            end else if (w_issue) begin
                r_ptr       <= r_ptr + ADDR_W'(1);
                r_last_addr <= r_ptr;
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= bus.readMem_val;
        end
    end

    assign bus.RDY_blockRead = (r_state == S_IDLE);
    assign bus.EN_readMem    = w_issue;
    assign bus.readMem_addr  = w_issue ? r_ptr : r_last_addr;
    assign bus.VALID_memVal  = w_valid;
    assign bus.memVal_data   = w_valid ? r_buf[r_rd_ptr] : '0;
    assign bus.rd_busy       = (r_state != S_IDLE);
    assign bus.burst_done    = (r_state == S_DONE);
endmodule
